mem_stream_arb_mux: RTL and testbench
=====================================

Name: mem_stream_arb_mux

Overview:
- Parametrised successor to the fixed 12:1 memory-output mux.
- Arbitrates among N_CHAN FWFT memory read ports and pops one word per accepted cycle. Emits a tagged word stream {tag, data} under a valid/ready handshake.
- Inserts a BX-boundary marker word whenever BX changes.
- Sits between the per-memory readout FIFOs and the serial link/stream packer.

Parameters:
- N_CHAN, 12, number of input channels (1..2^TAG_W-2).
- DATA_W, 44, data width per channel.
- TAG_W, 4, tag width; channel i carries tag i+1. Tag 0 is never emitted; all-ones is the marker tag.
- BX_W, 3, width of the BX bunch counter.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- BX  in  BX_W  current bunch-crossing number.
- ch_valid  in  N_CHAN  channel i has a word at its head (FWFT).
- ch_dat  in  N_CHAN*DATA_W  head data; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_rd  out  N_CHAN  one-hot pop strobe; at most one bit high per cycle.
- out_ready  in  1  downstream accepts out_dat this cycle.
- out_valid  out  1  out_dat holds a word.
- out_dat  out  TAG_W+DATA_W  {tag, payload}.
- marker_ovf  out  1  sticky: a BX change was merged into a still-pending marker.

Behaviour:
- Reset, synchronous, active-high:
  - out_valid=0, out_dat=0, ch_rd=0, marker_ovf=0.
  - RR pointer=0, marker_pend=0.
  - bx_q<=BX, so no marker is emitted after reset.
- Asserting reset mid-transfer drops the held output word. No ch_rd is issued in the reset cycle.
- Load enable: load = !out_valid || out_ready. The output register is a single stage with no skid buffer.
- BX edge: bx_q<=BX every cycle. If BX!=bx_q, set marker_pend.
  - If marker_pend is already set and not being cleared this cycle, set marker_ovf.
  - The marker carries the latest BX value.
- Grant priority on load:
  1. marker_pend: out_dat={all-ones, zero-extended bx_q}, out_valid=1, clear marker_pend, no ch_rd.
     - If a new BX edge occurs in the same cycle the marker loads, marker_pend stays set.
  2. Otherwise, if any ch_valid bit is set: select channel g.
     - RR_MODE=0: g = lowest set index.
     - RR_MODE=1: g = first set index at or after ptr, wrapping modulo N_CHAN; then ptr <= (g+1) mod N_CHAN, with wrap at N_CHAN-1 -> 0.
     - out_dat={g+1, ch_dat[g]}, out_valid=1, ch_rd[g]=1 for this single cycle (registered decision, combinational strobe in the load cycle).
  3. Otherwise: out_valid<=0. out_dat holds its previous value (not zeroed).
- When load=0 (out_valid && !out_ready): out_dat is stable, ch_rd=0, ptr unchanged, marker stays pending.
- Latency: ch_valid rising -> out_valid high on the next clk edge (1 cycle).
- Throughput: 1 word/cycle while out_ready=1.
- ch_rd is only asserted when ch_valid of that channel is 1 in the same cycle. The upstream FIFO updates its head on the following edge.
- Tag arithmetic: g+1 is truncated to TAG_W bits. The N_CHAN bound guarantees it never equals all-ones.
- Payload of a marker: BX in the low BX_W bits, upper DATA_W-BX_W bits zero.

Test Plan:
- Reset, then ch_valid=12'h000, BX constant for 10 cycles -> out_valid=0, ch_rd=0, no marker.
- RR_MODE=0, ch_valid=12'h024 held, out_ready=1, FIFO model pops:
  - cycle-by-cycle tags are 3 (ch2) until ch2 empties, then 6 (ch5).
  - ch_rd sequence matches, one-hot.
- RR_MODE=1, all 12 channels valid continuously, out_ready=1:
  - tags cycle 1,2,...,12,1,...
  - after channel 11 the pointer wraps to 0.
- out_ready=0 for 5 cycles with words available:
  - out_dat is held constant and ch_rd=0 throughout.
  - on release the next word appears one per cycle, with no loss or duplication (scoreboard).
- BX 3->4 while streaming -> exactly one word {4'hF, 44'd4} inserted before the next channel word. marker_ovf stays 0.
- BX 3->4->5 on consecutive cycles with out_ready=0:
  - one marker with payload 5 is emitted.
  - marker_ovf=1 and remains set until reset.
  - reset asserted mid-stall -> out_valid=0, marker_ovf=0 on the next edge.

Source files
------------

// File: rtl/mem_stream_arb_mux.sv
// N-channel FWFT readout arbiter producing a {tag, data} stream with BX-boundary markers.
// One output register with no skid buffer; a pending marker always wins over channel data.
module mem_stream_arb_mux #(
    parameter int N_CHAN  = 12,
    parameter int DATA_W  = 44,
    parameter int TAG_W   = 4,
    parameter int BX_W    = 3,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BX_W-1:0]          BX,
    input  logic [N_CHAN-1:0]        ch_valid,
    input  logic [N_CHAN*DATA_W-1:0] ch_dat,
    output logic [N_CHAN-1:0]        ch_rd,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [TAG_W+DATA_W-1:0]  out_dat,
    output logic                     marker_ovf
);
    localparam int PTR_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int OUT_W = TAG_W + DATA_W;

    logic [BX_W-1:0]   bx_q;
    logic              markerPend_q, markerPend_d;
    logic              markerOvf_q, markerOvf_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              outValid_q;
    logic [OUT_W-1:0]  outDat_q;

    logic              load, bxEdge, markerLoad, found, grantFire;
    logic [PTR_W-1:0]  startIdx, grantIdx, candIdx;
    logic [OUT_W-1:0]  markerWord, chanWord;
    logic [DATA_W-1:0] chWord [N_CHAN];
    int                cand;

    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_unpack
        assign chWord[gi] = ch_dat[gi*DATA_W +: DATA_W];
    end

    assign load       = !outValid_q || out_ready;
    assign bxEdge     = (BX != bx_q);
    assign markerLoad = load && markerPend_q;
    assign grantFire  = !reset && load && !markerPend_q && found;
    assign startIdx   = (RR_MODE != 0) ? ptr_q : '0;

    // Scan once around the ring starting at startIdx; fixed priority simply starts at 0.
    always_comb begin
        found    = 1'b0;
        grantIdx = '0;
        cand     = 0;
        candIdx  = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            cand = int'(startIdx) + k;
            if (cand >= N_CHAN) cand = cand - N_CHAN;
            candIdx = PTR_W'(cand);
            if (!found && ch_valid[candIdx]) begin
                found    = 1'b1;
                grantIdx = candIdx;
            end
        end
    end

    assign markerWord = {{TAG_W{1'b1}}, {(DATA_W-BX_W){1'b0}}, bx_q};
    assign chanWord   = {TAG_W'(int'(grantIdx) + 1), chWord[grantIdx]};

    always_comb begin
        ptr_d = ptr_q;
        if (grantFire && RR_MODE != 0)
            ptr_d = (int'(grantIdx) == N_CHAN - 1) ? '0 : grantIdx + PTR_W'(1);
    end

    always_comb begin
        ch_rd = '0;
        if (grantFire) ch_rd[grantIdx] = 1'b1;
    end

    // A BX edge arriving while the marker is loading re-arms it for the new value.
    assign markerPend_d = bxEdge || (markerPend_q && !markerLoad);
    assign markerOvf_d  = markerOvf_q || (bxEdge && markerPend_q && !markerLoad);

    always_ff @(posedge clk) begin
        if (reset) begin
            bx_q         <= BX;
            markerPend_q <= 1'b0;
            markerOvf_q  <= 1'b0;
            ptr_q        <= '0;
            outValid_q   <= 1'b0;
            outDat_q     <= '0;
        end else begin
            bx_q         <= BX;
            markerPend_q <= markerPend_d;
            markerOvf_q  <= markerOvf_d;
            ptr_q        <= ptr_d;
            if (load) begin
                if (markerPend_q) begin
                    outValid_q <= 1'b1;
                    outDat_q   <= markerWord;
                end else if (found) begin
                    outValid_q <= 1'b1;
                    outDat_q   <= chanWord;
                end else begin
                    outValid_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_dat    = outDat_q;
    assign marker_ovf = markerOvf_q;
endmodule

// File: tb/tb_mem_stream_arb_mux.sv
// Bench for mem_stream_arb_mux: fixed-priority and round-robin instances driven from
// per-channel FIFO queues and compared every cycle against a queue-based reference model.
module tb_mem_stream_arb_mux;
    localparam int N  = 12;
    localparam int DW = 44;
    localparam int TW = 4;
    localparam int BW = 3;
    localparam int OW = TW + DW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [BW-1:0]        bx = 3'd3;
    logic                 outReady = 1'b1;
    logic [1:0][N-1:0]    chValid;
    logic [1:0][N*DW-1:0] chDat;
    logic [1:0][N-1:0]    chRd;
    logic [1:0]           outValid;
    logic [1:0][OW-1:0]   outDat;
    logic [1:0]           markerOvf;

    int errors = 0;
    int checks = 0;

    // Reference model state; index 0 = fixed priority, index 1 = round robin.
    bit            mValid [2];
    logic [OW-1:0] mDat [2];
    bit            mPend [2];
    bit            mOvf [2];
    logic [BW-1:0] mBx [2];
    int            mPtr [2];
    int            mGrant [2];
    bit            mLoad [2];
    logic [DW-1:0] fifo [2*N][$];

    int            pushed = 0;
    int            accepted [2];
    int            markersSeen [2];
    logic [DW-1:0] lastMarker [2];

    always #5 clk = ~clk;

    mem_stream_arb_mux #(.N_CHAN(N), .DATA_W(DW), .TAG_W(TW), .BX_W(BW), .RR_MODE(0)) dutFixed (
        .clk(clk), .reset(reset), .BX(bx), .ch_valid(chValid[0]), .ch_dat(chDat[0]),
        .ch_rd(chRd[0]), .out_ready(outReady), .out_valid(outValid[0]), .out_dat(outDat[0]),
        .marker_ovf(markerOvf[0]));

    mem_stream_arb_mux #(.N_CHAN(N), .DATA_W(DW), .TAG_W(TW), .BX_W(BW), .RR_MODE(1)) dutRr (
        .clk(clk), .reset(reset), .BX(bx), .ch_valid(chValid[1]), .ch_dat(chDat[1]),
        .ch_rd(chRd[1]), .out_ready(outReady), .out_valid(outValid[1]), .out_dat(outDat[1]),
        .marker_ovf(markerOvf[1]));

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input int ch);
        logic [DW-1:0] w;
        w = {12'($urandom), 32'($urandom)};
        fifo[ch].push_back(w);
        fifo[N+ch].push_back(w);
        pushed++;
    endtask

    // FWFT heads: valid = queue non-empty, data = queue front.
    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            logic [N-1:0]    v;
            logic [N*DW-1:0] d;
            v = '0;
            d = '0;
            for (int ch = N - 1; ch >= 0; ch--) begin
                v = {v[N-2:0], fifo[i*N+ch].size() > 0};
                d = {d[N*DW-DW-1:0], (fifo[i*N+ch].size() > 0) ? fifo[i*N+ch][0] : {DW{1'b0}}};
            end
            chValid[i] = v;
            chDat[i]   = d;
        end
    endtask

    task automatic modelComb(input int i);
        mLoad[i]  = !mValid[i] || outReady;
        mGrant[i] = -1;
        if (!reset && mLoad[i] && !mPend[i]) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (i == 1) ? (mPtr[i] + k) % N : k;
                if (mGrant[i] < 0 && fifo[i*N+c].size() > 0) mGrant[i] = c;
            end
        end
    endtask

    task automatic modelSeq(input int i);
        bit edgeNow;
        bit markerNow;
        if (reset) begin
            mValid[i] = 0;
            mDat[i]   = '0;
            mPend[i]  = 0;
            mOvf[i]   = 0;
            mPtr[i]   = 0;
            mBx[i]    = bx;
        end else begin
            edgeNow   = (bx != mBx[i]);
            markerNow = mLoad[i] && mPend[i];
            if (mLoad[i]) begin
                if (mPend[i]) begin
                    mValid[i] = 1;
                    mDat[i]   = {{TW{1'b1}}, {(DW-BW){1'b0}}, mBx[i]};
                end else if (mGrant[i] >= 0) begin
                    mValid[i] = 1;
                    mDat[i]   = {TW'(mGrant[i] + 1), fifo[i*N+mGrant[i]][0]};
                    void'(fifo[i*N+mGrant[i]].pop_front());
                    if (i == 1) mPtr[i] = (mGrant[i] + 1) % N;
                end else begin
                    mValid[i] = 0;
                end
            end
            if (edgeNow && mPend[i] && !markerNow) mOvf[i] = 1;
            mPend[i] = edgeNow || (mPend[i] && !markerNow);
            mBx[i]   = bx;
        end
    endtask

    task automatic tick();
        logic [N-1:0] expRd;
        applyStimulus();
        #1;
        for (int i = 0; i < 2; i++) begin
            modelComb(i);
            expRd = '0;
            if (mGrant[i] >= 0) expRd = N'(1) << mGrant[i];
            checkOutput($sformatf("ch_rd[%0d]", i), 64'(chRd[i]), 64'(expRd));
            if (outValid[i] && outReady && !reset) begin
                if (outDat[i][OW-1 -: TW] == {TW{1'b1}}) begin
                    markersSeen[i]++;
                    lastMarker[i] = outDat[i][DW-1:0];
                end else begin
                    accepted[i]++;
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) modelSeq(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("out_valid[%0d]", i), 64'(outValid[i]), 64'(mValid[i]));
            checkOutput($sformatf("out_dat[%0d]", i), 64'(outDat[i]), 64'(mDat[i]));
            checkOutput($sformatf("marker_ovf[%0d]", i), 64'(markerOvf[i]), 64'(mOvf[i]));
        end
    endtask

    function automatic bit anyQueued();
        for (int q = 0; q < 2 * N; q++) if (fifo[q].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drainAll();
        int guard;
        guard    = 0;
        outReady = 1'b1;
        while (guard < 300 && (anyQueued() || mValid[0] || mValid[1] || mPend[0] || mPend[1])) begin
            tick();
            guard++;
        end
        checkOutput("drainBound", 64'(guard < 300), 64'(1));
    endtask

    initial begin
        accepted    = '{0, 0};
        markersSeen = '{0, 0};

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();

        repeat (3) pushWord(2);
        repeat (4) pushWord(5);
        repeat (10) tick();

        for (int r = 0; r < 3; r++)
            for (int ch = 0; ch < N; ch++) pushWord(ch);
        repeat (26) tick();

        outReady = 1'b0;
        repeat (5) tick();
        drainAll();
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("noLossAfterStall[%0d]", i), 64'(accepted[i]), 64'(pushed));

        for (int r = 0; r < 2; r++)
            for (int ch = 0; ch < N; ch++) pushWord(ch);
        markersSeen = '{0, 0};
        repeat (3) tick();
        bx = 3'd4;
        repeat (6) tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("singleMarker[%0d]", i), 64'(markersSeen[i]), 64'(1));
            checkOutput($sformatf("markerPayload4[%0d]", i), 64'(lastMarker[i]), 64'(4));
            checkOutput($sformatf("noOvf[%0d]", i), 64'(markerOvf[i]), 64'(0));
        end
        drainAll();

        repeat (160) begin
            if ($urandom_range(0, 2) == 0) pushWord(int'($urandom_range(0, N - 1)));
            outReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) bx = bx + 3'd1;
            tick();
        end
        drainAll();
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("noLossRandom[%0d]", i), 64'(accepted[i]), 64'(pushed));

        bx = 3'd3;
        repeat (8) pushWord(0);
        repeat (8) pushWord(7);
        repeat (4) tick();
        outReady = 1'b0;
        tick();
        bx = 3'd4;
        tick();
        bx = 3'd5;
        tick();
        tick();
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("ovfSet[%0d]", i), 64'(markerOvf[i]), 64'(1));
        markersSeen = '{0, 0};
        outReady = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("mergedMarker[%0d]", i), 64'(markersSeen[i]), 64'(1));
            checkOutput($sformatf("markerPayload5[%0d]", i), 64'(lastMarker[i]), 64'(5));
            checkOutput($sformatf("ovfSticky[%0d]", i), 64'(markerOvf[i]), 64'(1));
        end
        outReady = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("rstValid[%0d]", i), 64'(outValid[i]), 64'(0));
            checkOutput($sformatf("rstOvf[%0d]", i), 64'(markerOvf[i]), 64'(0));
        end
        reset = 1'b0;
        outReady = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
